// File: rtl/scope_capture.sv
// scope_capture: triggered sample-capture buffer for the scope path.
//
// The arm pulse starts a capture. Samples then flow into a circular buffer
// and roll over silently. A trigger is qualified only once the pre-trigger
// window is full. After a qualified trigger, exactly npost_l samples are
// captured, the trigger sample included. The record is then frozen and
// read out oldest first.
//
// Ports:
//   clk        in   rising-edge sample/system clock
//   reset_n    in   asynchronous active-low reset
//   arm        in   one-cycle pulse: abort any capture, start a new one
//   npost      in   post-trigger sample count, sampled on arm
//   trigger    in   trigger qualifier, only meaningful with din_latch
//   din        in   sample data
//   din_latch  in   din valid this cycle
//   dout       out  oldest unread sample (combinational from memory)
//   dout_pop   in   consume dout
//   dout_ready out  record complete and buffer not empty
//   dout_count out  samples held, 0..DEPTH
//   busy       out  capture in progress (PRE or POST)
//   done       out  record complete (DONE)
//
// Readout handshake: a sample transfers on a rising edge where dout_pop and
// dout_ready are both high. dout_pop while dout_ready is low has no effect.
module scope_capture #(
  parameter int N     = 8,
  parameter int NSAMP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic [NSAMP:0]   npost,
  input  logic             trigger,
  input  logic [N-1:0]     din,
  input  logic             din_latch,
  output logic [N-1:0]     dout,
  input  logic             dout_pop,
  output logic             dout_ready,
  output logic [NSAMP:0]   dout_count,
  output logic             busy,
  output logic             done
);

  localparam int DEPTH = 1 << NSAMP;
  localparam logic [NSAMP:0] DEPTH_C = (NSAMP+1)'(DEPTH);
  localparam logic [NSAMP:0] ONE_C   = (NSAMP+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [NSAMP:0] wptr_q, wptr_d;
  logic [NSAMP:0] rptr_q, rptr_d;
  logic [NSAMP:0] remaining_q, remaining_d;
  logic [NSAMP:0] npost_l_q, npost_l_d;

  logic [N-1:0]   mem [DEPTH];

  logic [NSAMP:0] count;
  logic           empty;
  logic           full;
  logic [NSAMP:0] npost_clamped;
  logic [NSAMP:0] trig_thresh;
  logic           mem_we;

  // The pointers carry an extra wrap bit. Their modular difference is
  // therefore the occupancy, and it can express the full DEPTH.
  assign count       = wptr_q - rptr_q;
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  // The pre-trigger window is full once count reaches DEPTH - npost_l.
  assign trig_thresh = DEPTH_C - npost_l_q;

  always_comb begin
    npost_clamped = npost;
    if (npost == '0) begin
      npost_clamped = ONE_C;
    end else if (npost > DEPTH_C) begin
      npost_clamped = DEPTH_C;
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    remaining_d = remaining_q;
    npost_l_d   = npost_l_q;
    mem_we      = 1'b0;

    if (arm) begin
      // arm overrides any sample, trigger or pop in the same cycle
      state_d     = ST_PRE;
      wptr_d      = '0;
      rptr_d      = '0;
      remaining_d = '0;
      npost_l_d   = npost_clamped;
    end else begin
      case (state_q)
        ST_PRE: begin
          if (din_latch) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + ONE_C;
            if (full) begin
              rptr_d = rptr_q + ONE_C;
            end
            // count is taken before this write; the trigger sample is
            // itself the first post-trigger sample
            if (trigger && (count >= trig_thresh)) begin
              remaining_d = npost_l_q - ONE_C;
              state_d     = (npost_l_q == ONE_C) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (din_latch) begin
            mem_we      = 1'b1;
            wptr_d      = wptr_q + ONE_C;
            if (full) begin
              rptr_d = rptr_q + ONE_C;
            end
            remaining_d = remaining_q - ONE_C;
            if (remaining_q == ONE_C) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (dout_pop && !empty) begin
            rptr_d = rptr_q + ONE_C;
          end
        end
        default: begin
          // IDLE: everything except arm is ignored
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      remaining_q <= '0;
      npost_l_q   <= ONE_C;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      remaining_q <= remaining_d;
      npost_l_q   <= npost_l_d;
    end
  end

  // The sample memory is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_q[NSAMP-1:0]] <= din;
    end
  end

  assign dout       = mem[rptr_q[NSAMP-1:0]];
  assign dout_count = count;
  assign busy       = (state_q == ST_PRE) || (state_q == ST_POST);
  assign done       = (state_q == ST_DONE);
  assign dout_ready = done && !empty;

endmodule
